// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares a single cache port between a read-only fetch requester (A) and a
//   read/write data requester (B). Ties are broken round-robin, starting with
//   B after reset. B accesses to odd addresses are rejected without touching
//   the cache. A transaction that gets no c_ready within TIMEOUT cycles is
//   aborted and reported as an error.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   a_req, a_addr                   fetch request (read only)
//   a_done, a_err, a_rdata          fetch completion / error pulse, read data
//   b_req, b_write, b_addr, b_wdata data request
//   b_done, b_err, b_rdata          data completion / error pulse, read data
//   c_req, c_write, c_addr, c_wdata shared cache request
//   c_ready, c_rdata                cache completion pulse and read data
//   busy                            high whenever the FSM is not idle
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | arbitrate; latch the winner's request
// ISSUE  | first cycle the request is on the cache port
// WAIT   | request still held, waiting for c_ready or timeout
// RESP   | one-cycle done/err pulse to the winner

module cache_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [15:0] a_addr,
    output logic        a_done,
    output logic        a_err,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_write,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_done,
    output logic        b_err,
    output logic [15:0] b_rdata,
    output logic        c_req,
    output logic        c_write,
    output logic [15:0] c_addr,
    output logic [15:0] c_wdata,
    input  logic        c_ready,
    input  logic [15:0] c_rdata,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Counter value in the last cycle the cache is given to answer.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,   state_d;
    logic        winner_b_q, winner_b_d;  // 1: current transaction belongs to B
    logic        last_b_q,  last_b_d;     // 1: B was granted most recently
    logic        err_q,     err_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [15:0] addr_q,    addr_d;
    logic        write_q,   write_d;
    logic [15:0] wdata_q,   wdata_d;
    logic [15:0] a_rdata_q, a_rdata_d;
    logic [15:0] b_rdata_q, b_rdata_d;
    logic        grant_b;

    always_comb begin
        state_d    = state_q;
        winner_b_d = winner_b_q;
        last_b_d   = last_b_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        grant_b    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    // B wins when alone, or on a tie when A was granted last.
                    grant_b    = b_req && (!a_req || !last_b_q);
                    winner_b_d = grant_b;
                    last_b_d   = grant_b;
                    cnt_d      = 8'd0;
                    if (grant_b) begin
                        addr_d  = b_addr;
                        write_d = b_write;
                        wdata_d = b_wdata;
                        // Odd B addresses are unaligned words: answer with an error directly.
                        err_d   = b_addr[0];
                        state_d = b_addr[0] ? ST_RESP : ST_ISSUE;
                    end else begin
                        addr_d  = a_addr;
                        write_d = 1'b0;
                        wdata_d = 16'd0;
                        err_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (c_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                    if (!winner_b_q) begin
                        a_rdata_d = c_rdata;
                    end else if (!write_q) begin
                        b_rdata_d = c_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                // Always return to IDLE so a held request cannot be re-granted here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            winner_b_q <= 1'b0;
            last_b_q   <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
            addr_q     <= 16'd0;
            write_q    <= 1'b0;
            wdata_q    <= 16'd0;
            a_rdata_q  <= 16'd0;
            b_rdata_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            winner_b_q <= winner_b_d;
            last_b_q   <= last_b_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    // Cache bus is driven only while a request is outstanding, quiet otherwise.
    assign c_req   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign c_write = c_req ? write_q : 1'b0;
    assign c_addr  = c_req ? addr_q  : 16'd0;
    assign c_wdata = c_req ? wdata_q : 16'd0;

    assign a_done  = (state_q == ST_RESP) && !winner_b_q && !err_q;
    assign a_err   = (state_q == ST_RESP) && !winner_b_q &&  err_q;
    assign b_done  = (state_q == ST_RESP) &&  winner_b_q && !err_q;
    assign b_err   = (state_q == ST_RESP) &&  winner_b_q &&  err_q;

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
//   Self-checking bench for cache_arbiter: directed scenarios followed by a
//   randomized run checked against a transaction-level reference model.

module tb_cache_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        a_req;
    logic [15:0] a_addr;
    logic        a_done, a_err;
    logic [15:0] a_rdata;
    logic        b_req, b_write;
    logic [15:0] b_addr, b_wdata;
    logic        b_done, b_err;
    logic [15:0] b_rdata;
    logic        c_req, c_write;
    logic [15:0] c_addr, c_wdata;
    logic        c_ready;
    logic [15:0] c_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_last_b;
    logic [15:0] m_a_rdata;
    logic [15:0] m_b_rdata;

    typedef struct {
        int          creq_cycles;
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wd;
        bit          unstable;
        int          a_done_n;
        int          a_err_n;
        int          b_done_n;
        int          b_err_n;
        int          resp_cycle;
        bit          excl_bad;
        bit          expired;
        logic        busy_after;
    } obs_t;

    cache_arbiter #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_req   (a_req),
        .a_addr  (a_addr),
        .a_done  (a_done),
        .a_err   (a_err),
        .a_rdata (a_rdata),
        .b_req   (b_req),
        .b_write (b_write),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_done  (b_done),
        .b_err   (b_err),
        .b_rdata (b_rdata),
        .c_req   (c_req),
        .c_write (c_write),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_ready (c_ready),
        .c_rdata (c_rdata),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_inputs();
        a_req = 0; a_addr = 0; b_req = 0; b_write = 0; b_addr = 0; b_wdata = 0;
        c_ready = 0; c_rdata = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        m_last_b  = 0;
        m_a_rdata = 0;
        m_b_rdata = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Drives one transaction from IDLE (called at a negedge) and records what
    // the DUT does. Cycle index 1 is the first cycle after the request edge.
    task automatic observe(input logic ar, input logic [15:0] aa,
                           input logic br, input logic bw, input logic [15:0] ba,
                           input logic [15:0] bd, input int rdy_delay,
                           input logic [15:0] rd, input int drop_at,
                           input bit hold, output obs_t o);
        int cyc;
        int pulses;
        bit seen;
        o = '{default: 0};
        a_req = ar; a_addr = aa;
        b_req = br; b_write = bw; b_addr = ba; b_wdata = bd;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 300) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            c_ready = 0;
            c_rdata = 16'($urandom);
            if (drop_at == cyc) a_req = 0;
            if (c_req) begin
                if (o.creq_cycles == 0) begin
                    o.addr = c_addr; o.wr = c_write; o.wd = c_wdata;
                end else if (c_addr !== o.addr || c_write !== o.wr || c_wdata !== o.wd) begin
                    o.unstable = 1;
                end
                if (o.creq_cycles == rdy_delay) begin
                    c_ready = 1;
                    c_rdata = rd;
                end
                o.creq_cycles++;
            end
            pulses = int'(a_done) + int'(a_err) + int'(b_done) + int'(b_err);
            o.a_done_n += int'(a_done); o.a_err_n += int'(a_err);
            o.b_done_n += int'(b_done); o.b_err_n += int'(b_err);
            if (pulses > 1) o.excl_bad = 1;
            if (pulses > 0) begin
                seen = 1;
                o.resp_cycle = cyc;
            end
        end
        o.expired = !seen;
        c_ready = 0;
        if (!hold) begin
            a_req = 0;
            b_req = 0;
        end
        @(posedge clk);
        @(negedge clk);
        o.a_done_n += int'(a_done); o.a_err_n += int'(a_err);
        o.b_done_n += int'(b_done); o.b_err_n += int'(b_err);
        o.busy_after = busy;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #12;
        total++; if (c_req !== 1'b0) begin bad++; $display("FAIL reset c_req: got %b want 0", c_req); end
        total++; if (c_write !== 1'b0 || c_addr !== 16'h0 || c_wdata !== 16'h0) begin
            bad++; $display("FAIL reset cache bus: got w=%b a=%h d=%h want 0", c_write, c_addr, c_wdata); end
        total++; if ({a_done, a_err, b_done, b_err} !== 4'b0) begin
            bad++; $display("FAIL reset pulses: got %b want 0000", {a_done, a_err, b_done, b_err}); end
        total++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
            bad++; $display("FAIL reset rdata: got a=%h b=%h want 0", a_rdata, b_rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        m_last_b = 0; m_a_rdata = 0; m_b_rdata = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy after release: got %b want 0", busy); end
    endtask

    // Done appears in the third cycle counting the cycle the request is sampled in.
    task automatic test_basic_read();
        obs_t o;
        observe(1, 16'h0010, 0, 0, 16'h0, 16'h0, 0, 16'hBEEF, -1, 0, o);
        total++; if (o.addr !== 16'h0010 || o.wr !== 1'b0 || o.wd !== 16'h0) begin
            bad++; $display("FAIL basic bus: got a=%h w=%b d=%h want 0010/0/0000", o.addr, o.wr, o.wd); end
        total++; if (o.resp_cycle !== 2 || o.a_done_n !== 1 || o.a_err_n !== 0) begin
            bad++; $display("FAIL basic done: got cyc=%0d done=%0d err=%0d want 2/1/0", o.resp_cycle, o.a_done_n, o.a_err_n); end
        total++; if (a_rdata !== 16'hBEEF) begin bad++; $display("FAIL basic a_rdata: got %h want beef", a_rdata); end
        total++; if (o.creq_cycles !== 1) begin bad++; $display("FAIL basic c_req len: got %0d want 1", o.creq_cycles); end
    endtask

    task automatic test_tie_round_robin();
        obs_t o;
        apply_reset();
        observe(1, 16'h0040, 1, 1, 16'h0020, 16'h1234, 0, 16'h5555, -1, 0, o);
        total++; if (o.b_done_n !== 1 || o.a_done_n !== 0) begin
            bad++; $display("FAIL tie1 winner: got b_done=%0d a_done=%0d want 1/0", o.b_done_n, o.a_done_n); end
        total++; if (o.addr !== 16'h0020 || o.wr !== 1'b1 || o.wd !== 16'h1234) begin
            bad++; $display("FAIL tie1 bus: got a=%h w=%b d=%h want 0020/1/1234", o.addr, o.wr, o.wd); end
        total++; if (b_rdata !== 16'h0) begin bad++; $display("FAIL tie1 write b_rdata: got %h want 0000", b_rdata); end
        observe(1, 16'h0040, 0, 0, 16'h0, 16'h0, 0, 16'h4321, -1, 0, o);
        total++; if (o.a_done_n !== 1 || o.addr !== 16'h0040) begin
            bad++; $display("FAIL tie2 A next: got a_done=%0d addr=%h want 1/0040", o.a_done_n, o.addr); end
        observe(1, 16'h0044, 1, 0, 16'h0030, 16'h0, 1, 16'h7777, -1, 0, o);
        total++; if (o.b_done_n !== 1 || o.a_done_n !== 0 || o.addr !== 16'h0030) begin
            bad++; $display("FAIL tie3 winner: got b_done=%0d a_done=%0d addr=%h want 1/0/0030", o.b_done_n, o.a_done_n, o.addr); end
        total++; if (b_rdata !== 16'h7777 || a_rdata !== 16'h4321) begin
            bad++; $display("FAIL tie3 rdata: got b=%h a=%h want 7777/4321", b_rdata, a_rdata); end
    endtask

    task automatic test_odd_addr();
        obs_t o;
        observe(0, 16'h0, 1, 1, 16'h0021, 16'hAAAA, 0, 16'h0, -1, 0, o);
        total++; if (o.creq_cycles !== 0) begin bad++; $display("FAIL odd c_req: got %0d cycles want 0", o.creq_cycles); end
        total++; if (o.b_err_n !== 1 || o.b_done_n !== 0 || o.resp_cycle !== 1) begin
            bad++; $display("FAIL odd err: got err=%0d done=%0d cyc=%0d want 1/0/1", o.b_err_n, o.b_done_n, o.resp_cycle); end
    endtask

    task automatic test_timeout();
        obs_t o;
        observe(1, 16'h0100, 0, 0, 16'h0, 16'h0, 1000, 16'h0, -1, 0, o);
        total++; if (o.creq_cycles !== TO) begin bad++; $display("FAIL timeout c_req len: got %0d want %0d", o.creq_cycles, TO); end
        total++; if (o.a_err_n !== 1 || o.a_done_n !== 0 || o.resp_cycle !== TO + 1) begin
            bad++; $display("FAIL timeout err: got err=%0d done=%0d cyc=%0d want 1/0/%0d", o.a_err_n, o.a_done_n, o.resp_cycle, TO + 1); end
        total++; if (o.busy_after !== 1'b0 || o.unstable) begin
            bad++; $display("FAIL timeout end: got busy=%b unstable=%0d want 0/0", o.busy_after, o.unstable); end
        total++; if (a_rdata !== 16'h4321) begin bad++; $display("FAIL timeout a_rdata: got %h want 4321", a_rdata); end
    endtask

    task automatic test_drop_req();
        obs_t o;
        observe(1, 16'h0200, 0, 0, 16'h0, 16'h0, 5, 16'h00FF, 2, 0, o);
        total++; if (o.a_done_n !== 1 || o.resp_cycle !== 7) begin
            bad++; $display("FAIL drop done: got done=%0d cyc=%0d want 1/7", o.a_done_n, o.resp_cycle); end
        total++; if (a_rdata !== 16'h00FF) begin bad++; $display("FAIL drop a_rdata: got %h want 00ff", a_rdata); end
    endtask

    task automatic test_idle_ready();
        int stray;
        stray = 0;
        @(negedge clk);
        c_ready = 1; c_rdata = 16'hDEAD;
        repeat (3) begin
            @(negedge clk);
            if (busy || c_req || a_done || a_err || b_done || b_err) stray++;
        end
        c_ready = 0;
        total++; if (stray !== 0) begin bad++; $display("FAIL idle_ready activity: got %0d cycles want 0", stray); end
        total++; if (a_rdata !== 16'h00FF || b_rdata !== 16'h7777) begin
            bad++; $display("FAIL idle_ready rdata: got a=%h b=%h want 00ff/7777", a_rdata, b_rdata); end
    endtask

    task automatic test_no_regrant();
        obs_t o;
        observe(1, 16'h0300, 0, 0, 16'h0, 16'h0, 0, 16'h1111, -1, 1, o);
        total++; if (o.a_done_n !== 1 || o.busy_after !== 1'b0) begin
            bad++; $display("FAIL regrant bubble: got done=%0d busy=%b want 1/0", o.a_done_n, o.busy_after); end
        @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1 || c_req !== 1'b1 || c_addr !== 16'h0300) begin
            bad++; $display("FAIL regrant second: got busy=%b c_req=%b addr=%h want 1/1/0300", busy, c_req, c_addr); end
        c_ready = 1; c_rdata = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        c_ready = 0;
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL regrant second done: got %b want 1", a_done); end
        a_req = 0;
        @(negedge clk);
        total++; if (a_rdata !== 16'h2222 || busy !== 1'b0) begin
            bad++; $display("FAIL regrant end: got a=%h busy=%b want 2222/0", a_rdata, busy); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int stray;
        stray = 0;
        @(negedge clk);
        a_req = 1; a_addr = 16'h0500;
        repeat (2) @(negedge clk);
        total++; if (c_req !== 1'b1) begin bad++; $display("FAIL rstmid pre c_req: got %b want 1", c_req); end
        #2 rst_n = 0;
        #1;
        total++; if (c_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid async: got c_req=%b busy=%b want 0/0", c_req, busy); end
        total++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
            bad++; $display("FAIL rstmid rdata: got a=%h b=%h want 0/0", a_rdata, b_rdata); end
        m_last_b = 0; m_a_rdata = 0; m_b_rdata = 0;
        @(negedge clk);
        a_req = 0;
        if (a_done || a_err || b_done || b_err) stray++;
        @(negedge clk);
        rst_n = 1;
        repeat (2) begin
            @(negedge clk);
            if (a_done || a_err || b_done || b_err || busy) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL rstmid stray: got %0d cycles want 0", stray); end
        observe(1, 16'h0400, 0, 0, 16'h0, 16'h0, 1, 16'h2468, -1, 0, o);
        total++; if (o.a_done_n !== 1 || o.resp_cycle !== 3 || a_rdata !== 16'h2468) begin
            bad++; $display("FAIL rstmid fresh: got done=%0d cyc=%0d a=%h want 1/3/2468", o.a_done_n, o.resp_cycle, a_rdata); end
    endtask

    task automatic test_random();
        obs_t o;
        logic ar, br, bw;
        logic [15:0] aa, ba, bd, rd;
        int dly;
        bit win_b, odd, ok_txn;
        int e_creq, e_cyc;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            ar = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
            if (!ar && !br) ar = 1;
            aa = 16'($urandom);
            ba = 16'($urandom);
            ba[0] = ($urandom_range(0, 5) == 0);
            bw = 1'($urandom_range(0, 1));
            bd = 16'($urandom);
            rd = 16'($urandom);
            dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 3)) : int'($urandom_range(0, 4));

            // Model: tie goes to the port not granted last; odd B addresses are rejected.
            win_b = (ar && br) ? !m_last_b : br;
            m_last_b = win_b;
            odd = win_b && ba[0];
            ok_txn = !odd && (dly < TO);
            if (odd) begin
                e_creq = 0; e_cyc = 1;
            end else if (ok_txn) begin
                e_creq = dly + 1; e_cyc = dly + 2;
                if (!win_b) m_a_rdata = rd;
                else if (!bw) m_b_rdata = rd;
            end else begin
                e_creq = TO; e_cyc = TO + 1;
            end

            observe(ar, aa, br, bw, ba, bd, dly, rd, -1, 0, o);

            total++; if (o.a_done_n !== int'(!win_b && ok_txn) || o.a_err_n !== int'(!win_b && !ok_txn) ||
                         o.b_done_n !== int'(win_b && ok_txn) || o.b_err_n !== int'(win_b && !ok_txn)) begin
                bad++; $display("FAIL rnd%0d pulses: got ad=%0d ae=%0d bd=%0d be=%0d want winner_b=%0d ok=%0d",
                                i, o.a_done_n, o.a_err_n, o.b_done_n, o.b_err_n, win_b, ok_txn); end
            total++; if (o.creq_cycles !== e_creq || o.resp_cycle !== e_cyc) begin
                bad++; $display("FAIL rnd%0d timing: got creq=%0d cyc=%0d want %0d/%0d", i, o.creq_cycles, o.resp_cycle, e_creq, e_cyc); end
            if (e_creq > 0) begin
                total++; if (o.addr !== (win_b ? ba : aa) || o.wr !== (win_b ? bw : 1'b0) ||
                             o.wd !== (win_b ? bd : 16'h0) || o.unstable) begin
                    bad++; $display("FAIL rnd%0d bus: got a=%h w=%b d=%h unstable=%0d want a=%h w=%b d=%h",
                                    i, o.addr, o.wr, o.wd, o.unstable, win_b ? ba : aa, win_b ? bw : 1'b0, win_b ? bd : 16'h0); end
            end
            total++; if (a_rdata !== m_a_rdata || b_rdata !== m_b_rdata) begin
                bad++; $display("FAIL rnd%0d rdata: got a=%h b=%h want %h/%h", i, a_rdata, b_rdata, m_a_rdata, m_b_rdata); end
            total++; if (o.excl_bad || o.expired || o.busy_after !== 1'b0) begin
                bad++; $display("FAIL rnd%0d misc: got excl=%0d expired=%0d busy=%b want 0/0/0", i, o.excl_bad, o.expired, o.busy_after); end
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_basic_read();
        test_tie_round_robin();
        test_odd_addr();
        test_timeout();
        test_drop_req();
        test_idle_ready();
        test_no_regrant();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
